// File: rtl/dac_pkg.sv
// Shared definitions for the LTC2624-style DAC SPI link: command codes,
// frame field positions and the responder state encoding.
package dac_pkg;
    localparam int FRAME_BITS = 32;
    localparam int NUM_CH     = 4;
    localparam int DAC_W      = 12;

    localparam logic [3:0] CMD_WRITE            = 4'h0;
    localparam logic [3:0] CMD_UPDATE           = 4'h1;
    localparam logic [3:0] CMD_WRITE_UPDATE_ALL = 4'h2;
    localparam logic [3:0] CMD_WRITE_UPDATE     = 4'h3;
    localparam logic [3:0] CMD_NOP              = 4'hF;
    localparam logic [3:0] ADDR_ALL             = 4'hF;

    localparam int CMD_MSB  = 23;
    localparam int CMD_LSB  = 20;
    localparam int ADDR_MSB = 19;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for one bus pin with registered rise/fall pulses.
// The level output is delayed to line up with the edge pulses.
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev   <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev   <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev;
            fall   <= ~sync_q[STAGES-1] & prev;
        end
    end

    assign dout = prev;
endmodule

// File: rtl/dac_spi_responder.sv
// Oversampling SPI responder modelling a quad 12-bit DAC: decodes 32-bit
// frames into per-channel input/DAC registers and echoes the last good frame.
module dac_spi_responder #(
    parameter int FRAME_BITS  = dac_pkg::FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        SPI_SCK,
    input  logic        DAC_CS,
    input  logic        SPI_MOSI,
    input  logic        DAC_CLR,
    output logic        DAC_OUT,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  cmd,
    output logic [3:0]  addr,
    output logic [11:0] data,
    output logic [11:0] dac_a,
    output logic [11:0] dac_b,
    output logic [11:0] dac_c,
    output logic [11:0] dac_d
);
    import dac_pkg::*;

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic clr_n_lvl, clr_rise, clr_fall;
    logic sync_unused;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(CLK50MHZ), .rst_n(RST), .din(SPI_SCK),
        .dout(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(CLK50MHZ), .rst_n(RST), .din(DAC_CS),
        .dout(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(CLK50MHZ), .rst_n(RST), .din(SPI_MOSI),
        .dout(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clr (
        .clk(CLK50MHZ), .rst_n(RST), .din(DAC_CLR),
        .dout(clr_n_lvl), .rise(clr_rise), .fall(clr_fall));

    assign sync_unused = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall, clr_rise, clr_fall};

    state_t                state, next_state;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [FRAME_BITS-1:0] echo;
    logic [FRAME_BITS-2:0] tx_shift;
    logic                  load_tx, do_decode, do_err, frame_ok;

    assign frame_ok = (bit_cnt == 6'(FRAME_BITS));

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (cs_fall) next_state = ST_SHIFT;
            ST_SHIFT:  if (cs_rise) next_state = ST_DECODE;
            ST_DECODE: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        load_tx   = (state == ST_IDLE) && cs_fall;
        do_decode = (state == ST_SHIFT) && cs_rise && frame_ok;
        do_err    = (state == ST_SHIFT) && cs_rise && !frame_ok;
    end

    // Echo is kept apart from the transmit shifter so a bad frame leaves it intact.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            echo        <= '0;
            DAC_OUT     <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            cmd         <= '0;
            addr        <= '0;
            data        <= '0;
        end else begin
            frame_valid <= do_decode;
            frame_err   <= do_err;
            if (load_tx) begin
                bit_cnt  <= '0;
                tx_shift <= echo[FRAME_BITS-2:0];
                DAC_OUT  <= echo[FRAME_BITS-1];
            end else if (state == ST_SHIFT) begin
                if (sck_rise) begin
                    rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_lvl};
                    if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
                end
                if (sck_fall) begin
                    DAC_OUT  <= tx_shift[FRAME_BITS-2];
                    tx_shift <= {tx_shift[FRAME_BITS-3:0], 1'b0};
                end
            end
            if (do_decode) begin
                echo <= rx_shift;
                cmd  <= rx_shift[CMD_MSB:CMD_LSB];
                addr <= rx_shift[ADDR_MSB:ADDR_LSB];
                data <= rx_shift[DATA_MSB:DATA_LSB];
            end
        end
    end

    logic [3:0]                         f_cmd, f_addr;
    logic [DAC_W-1:0]                   f_data;
    logic                               addr_ok;
    logic [NUM_CH-1:0]                  ch_sel;
    logic [NUM_CH-1:0][DAC_W-1:0]       in_reg, dac_reg, in_nxt, dac_nxt;

    assign f_cmd   = rx_shift[CMD_MSB:CMD_LSB];
    assign f_addr  = rx_shift[ADDR_MSB:ADDR_LSB];
    assign f_data  = rx_shift[DATA_MSB:DATA_LSB];
    assign addr_ok = (f_addr < 4'(NUM_CH)) || (f_addr == ADDR_ALL);

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++)
            ch_sel[ch] = (f_addr == 4'(ch)) || (f_addr == ADDR_ALL);
    end

    // Addresses outside A-D/ALL leave every register untouched.
    always_comb begin
        in_nxt  = in_reg;
        dac_nxt = dac_reg;
        if (do_decode && addr_ok) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                case (f_cmd)
                    CMD_WRITE:            if (ch_sel[ch]) in_nxt[ch] = f_data;
                    CMD_UPDATE:           if (ch_sel[ch]) dac_nxt[ch] = in_reg[ch];
                    CMD_WRITE_UPDATE_ALL: begin
                        if (ch_sel[ch]) in_nxt[ch] = f_data;
                        dac_nxt[ch] = ch_sel[ch] ? f_data : in_reg[ch];
                    end
                    CMD_WRITE_UPDATE: begin
                        if (ch_sel[ch]) begin
                            in_nxt[ch]  = f_data;
                            dac_nxt[ch] = f_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            in_reg  <= '0;
            dac_reg <= '0;
        end else if (!clr_n_lvl) begin
            in_reg  <= '0;
            dac_reg <= '0;
        end else begin
            in_reg  <= in_nxt;
            dac_reg <= dac_nxt;
        end
    end

    assign dac_a = dac_reg[0];
    assign dac_b = dac_reg[1];
    assign dac_c = dac_reg[2];
    assign dac_d = dac_reg[3];
endmodule

// File: tb/tb_dac_spi_responder.sv
// Directed bench for dac_spi_responder: a behavioural DAC model pushes the
// expected decode result per frame, a monitor pops it on each frame pulse.
module tb_dac_spi_responder;
    logic        CLK50MHZ = 1'b0;
    logic        RST, SPI_SCK, DAC_CS, SPI_MOSI, DAC_CLR;
    logic        DAC_OUT, frame_valid, frame_err;
    logic [3:0]  cmd, addr;
    logic [11:0] data, dac_a, dac_b, dac_c, dac_d;

    dac_spi_responder dut (
        .CLK50MHZ(CLK50MHZ), .RST(RST), .SPI_SCK(SPI_SCK), .DAC_CS(DAC_CS),
        .SPI_MOSI(SPI_MOSI), .DAC_CLR(DAC_CLR), .DAC_OUT(DAC_OUT),
        .frame_valid(frame_valid), .frame_err(frame_err), .cmd(cmd), .addr(addr),
        .data(data), .dac_a(dac_a), .dac_b(dac_b), .dac_c(dac_c), .dac_d(dac_d));

    always #10 CLK50MHZ = ~CLK50MHZ;

    typedef struct {
        logic        vld;
        logic [19:0] cad;
        logic [11:0] dv[4];
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [11:0] m_in[4];
    logic [11:0] m_dac[4];
    logic [31:0] m_echo;
    logic [19:0] m_cad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK50MHZ);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_in[i]  = '0;
            m_dac[i] = '0;
        end
        m_echo = '0;
        m_cad  = '0;
    endtask

    task automatic model_frame(input logic [31:0] w, input int nbits);
        exp_t        e;
        logic [3:0]  c, a;
        logic [11:0] d;
        logic        ok;
        c  = w[23:20];
        a  = w[19:16];
        d  = w[15:4];
        ok = (a < 4) || (a == 4'hF);
        if (nbits == 32) begin
            m_echo = w;
            m_cad  = {c, a, d};
            if (ok) begin
                for (int ch = 0; ch < 4; ch++) begin
                    if (a == ch[3:0] || a == 4'hF) begin
                        if (c == 4'h0 || c == 4'h2 || c == 4'h3) m_in[ch] = d;
                        if (c == 4'h1) m_dac[ch] = m_in[ch];
                        if (c == 4'h3) m_dac[ch] = d;
                    end
                end
                if (c == 4'h2)
                    for (int ch = 0; ch < 4; ch++) m_dac[ch] = m_in[ch];
            end
        end
        e.vld = (nbits == 32);
        e.cad = m_cad;
        for (int ch = 0; ch < 4; ch++) e.dv[ch] = m_dac[ch];
        sb.push_back(e);
    endtask

    // Drives nbits SCK pulses with the frame MSB first; samples DAC_OUT before each rise.
    task automatic clock_bits(input logic [31:0] w, input int nbits, output logic [31:0] echo_obs);
        echo_obs = '0;
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = (i < 32) ? w[31-i] : 1'b0;
            tick(6);
            if (i < 32) echo_obs[31-i] = DAC_OUT;
            SPI_SCK = 1'b1;
            tick(4);
            SPI_SCK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits, input string tag);
        logic [31:0] echo_exp, echo_obs;
        echo_exp = m_echo;
        model_frame(w, nbits);
        DAC_CS = 1'b0;
        tick(4);
        clock_bits(w, nbits, echo_obs);
        tick(6);
        DAC_CS = 1'b1;
        tick(10);
        if (nbits >= 32) check({tag, "_echo"}, echo_obs, echo_exp);
        check({tag, "_pending"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    always @(negedge CLK50MHZ) begin
        if (RST === 1'b1 && (frame_valid === 1'b1 || frame_err === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {frame_valid, frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_valid", frame_valid, e.vld);
                check("frame_err", frame_err, !e.vld);
                check("cmd_addr_data", {cmd, addr, data}, e.cad);
                check("dac_a", dac_a, e.dv[0]);
                check("dac_b", dac_b, e.dv[1]);
                check("dac_c", dac_c, e.dv[2]);
                check("dac_d", dac_d, e.dv[3]);
            end
        end
    end

    initial begin
        logic [31:0] dummy;
        RST = 1'b0; SPI_SCK = 1'b0; DAC_CS = 1'b1; SPI_MOSI = 1'b0; DAC_CLR = 1'b1;
        model_reset();
        tick(3);
        check("rst_dac_out", DAC_OUT, 1'b0);
        check("rst_pulses", {frame_valid, frame_err}, 2'b00);
        check("rst_cad", {cmd, addr, data}, 20'h0);
        check("rst_dacs", {dac_a, dac_b, dac_c, dac_d}, 32'h0);
        RST = 1'b1;
        tick(5);

        send_frame(32'h0030ABC0, 32, "wr_upd_a");
        send_frame(32'h00011230, 32, "wr_b");
        send_frame(32'h00110000, 32, "upd_b");
        send_frame(32'h003FFFF0, 32, "wr_upd_all");

        DAC_CLR = 1'b0;
        tick(4);
        DAC_CLR = 1'b1;
        model_reset();
        m_echo = 32'h003FFFF0;
        m_cad  = 20'h3FFFF;
        tick(8);
        check("clr_dacs_ab", {dac_a, dac_b}, 24'h0);
        check("clr_dacs_cd", {dac_c, dac_d}, 24'h0);
        check("clr_keeps_cad", {cmd, addr, data}, 20'h3FFFF);

        send_frame(32'h00000550, 32, "wr_a");
        send_frame(32'h00224560, 32, "wr_c_upd_all");
        send_frame(32'h00377770, 32, "bad_addr");
        send_frame(32'h00F01110, 32, "nop");
        send_frame(32'h12345678, 32, "pattern");
        send_frame(32'h00000000, 32, "echo_pattern");
        send_frame(32'h0031ABC0, 31, "short31");
        send_frame(32'h0031ABC0, 33, "long33");
        send_frame(32'h0031ABC0, 0,  "empty");
        send_frame(32'h00326660, 32, "after_errs");

        DAC_CS = 1'b0;
        tick(4);
        clock_bits(32'h0033DDD0, 17, dummy);
        RST = 1'b0;
        DAC_CS = 1'b1;
        #1;
        check("midrst_dac_out", DAC_OUT, 1'b0);
        check("midrst_cad", {cmd, addr, data}, 20'h0);
        check("midrst_dacs", {dac_a, dac_b, dac_c, dac_d}, 32'h0);
        model_reset();
        tick(3);
        RST = 1'b1;
        tick(5);
        send_frame(32'h00317E50, 32, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dac_spi_responder.md
# dac_spi_responder

Synthesizable SPI responder modelling the LTC2624 quad 12-bit DAC. It sits at the far end of the DAC SPI link (SPI_SCK/DAC_CS/SPI_MOSI/DAC_CLR in, DAC_OUT back) and runs in the CLK50MHZ domain by oversampling the bus. It decodes 32-bit command frames into four channel registers and echoes the previous frame on DAC_OUT. It serves as a loopback target and bench model for the DAC master.

## Interface
- FRAME_BITS, 32: bits per valid frame
- SYNC_STAGES, 2: synchronizer depth for SCK/CS/MOSI/CLR
- CLK50MHZ  in  1  system clock, all logic rising-edge
- RST  in  1  asynchronous, active-low reset
- SPI_SCK  in  1  serial clock from master, idle low
- DAC_CS  in  1  chip select, active low
- SPI_MOSI  in  1  serial data, MSB first, sampled on SCK rise
- DAC_CLR  in  1  active-low clear of all channel registers
- DAC_OUT  out  1  echo of previous frame, changes on SCK fall
- frame_valid  out  1  one-cycle pulse: complete frame decoded
- frame_err  out  1  one-cycle pulse: CS rose with bit count ≠ FRAME_BITS
- cmd  out  4  command of last valid frame
- addr  out  4  address of last valid frame
- data  out  12  data of last valid frame
- dac_a, dac_b, dac_c, dac_d  out  12 each  output (DAC) registers

## Operation
- Frame layout, MSB first: [31:24] don't-care, [23:20] cmd, [19:16] addr, [15:4] data, [3:0] don't-care.
- States: IDLE (CS high), SHIFT (CS low), DECODE (one cycle after CS rise).
- IDLE→SHIFT on synchronized CS fall: bit counter ← 0; DAC_OUT ← echo[31].
- SHIFT: each synchronized SCK rise shifts MOSI into rx_shift and increments the counter, which saturates at 63. Each SCK fall shifts echo left and drives the next echo bit on DAC_OUT.
- SHIFT→DECODE on CS rise. If counter == 32: latch cmd/addr/data, pulse frame_valid, and echo ← rx_shift. Otherwise pulse frame_err; registers and echo are unchanged. DECODE→IDLE next cycle.
- Each channel has an input register and a DAC register. Addr 0–3 selects A–D; addr 15 selects all; any other addr is ignored, but frame_valid still pulses.
- cmd 0000: write input reg.
- cmd 0001: update DAC reg from input reg.
- cmd 0010: write input reg, then update all DAC regs from input regs.
- cmd 0011: write and update the addressed channel.
- cmd 1111 and others: no-op.
- DAC_CLR low (synchronized): all input and DAC regs ← 0. CLR has priority over a same-cycle decode. The frame shift is not affected.
- Reset values: all registers 0, DAC_OUT 0, frame_valid 0, frame_err 0, state IDLE.
- CS rise with no SCK edges: counter 0 → frame_err.
- SCK edges while CS is high: ignored.

## Timing
- Input-to-internal latency: SYNC_STAGES cycles. Edge detect adds 1 cycle.
- Master constraints: SCK high ≥ 3 clk and low ≥ 3 clk (≥ 60 ns each). CS fall to first SCK rise ≥ 3 clk. Last SCK fall to CS rise ≥ 3 clk. CS high ≥ 4 clk between frames.
- frame_valid/frame_err: SYNC_STAGES+2 cycles after the CS pin rises.
- Channel regs update on the same edge frame_valid asserts.
- DAC_OUT is stable from SYNC_STAGES+2 cycles after SCK fall through the next SCK rise.

## Structure
- Shared package dac_pkg: command encodings (CMD_WRITE, CMD_UPDATE, CMD_WRITE_UPDATE_ALL, CMD_WRITE_UPDATE, CMD_NOP), ADDR_ALL = 4'hF, frame field bit positions, FRAME_BITS.
- Sub-module spi_edge_sync: N-stage synchronizer plus rise/fall pulse outputs, instantiated per input.

## Test plan
- Frame 0x00_3_0_ABC_0 (cmd 0011, addr 0, data 0xABC) → frame_valid; dac_a = 0xABC; B–D = 0.
- cmd 0000 addr 1 data 0x123, then cmd 0001 addr 1 → dac_b = 0 after the first frame, 0x123 after the second.
- cmd 0011 addr 15 data 0xFFF → dac_a..dac_d all 0xFFF. Then pulse DAC_CLR low for 4 clk → all 0.
- Two frames: 0x12345678, then any → DAC_OUT bits during the second frame reproduce 0x12345678 MSB first.
- Frame with 31 SCK pulses; frame with 33 → frame_err each time; registers and echo unchanged.
- Assert RST mid-frame after bit 16 → all outputs 0 immediately. The next full frame decodes correctly.
